// File: rtl/cls_sched_pkg.sv
// cls_sched_pkg: shared types and helpers for the classifier sequencer.
// Provides the FSM state encoding and frame word-count arithmetic.
package cls_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_STREAM,
        S_WAIT,
        S_PUBLISH
    } state_t;

    function automatic int words_for(input int cells, input int par);
        return (cells + par - 1) / par;
    endfunction

    function automatic int addr_bits(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/cls_scheduler_if.sv
// cls_scheduler_if: feature-buffer read port plus systolic-array bus.
// master = sequencer side (drives reads/beats), slave = buffer/array side.
interface cls_scheduler_if #(
    parameter int PARALLEL_INPUTS = 4,
    parameter int VALUE_BITS      = 6,
    parameter int NUM_CLASSES     = 4,
    parameter int ACC_BITS        = 24,
    parameter int WADDR_BITS      = 8
);
    localparam int FW = PARALLEL_INPUTS * VALUE_BITS;

    logic                            fm_rd_en;
    logic [WADDR_BITS-1:0]           fm_rd_addr;
    logic [FW-1:0]                   fm_rd_data;
    logic                            sa_start;
    logic [FW-1:0]                   sa_feature_in;
    logic                            sa_feature_valid;
    logic                            sa_result_valid;
    logic [1:0]                      sa_best_class;
    logic [NUM_CLASSES*ACC_BITS-1:0] sa_scores_flat;

    modport master (
        output fm_rd_en, fm_rd_addr,
        output sa_start, sa_feature_in, sa_feature_valid,
        input  fm_rd_data,
        input  sa_result_valid, sa_best_class, sa_scores_flat
    );

    modport slave (
        input  fm_rd_en, fm_rd_addr,
        input  sa_start, sa_feature_in, sa_feature_valid,
        output fm_rd_data,
        output sa_result_valid, sa_best_class, sa_scores_flat
    );

endinterface

// File: rtl/cls_margin.sv
// cls_margin: best score, second-best score and confidence compare.
// In: scores_flat, best_class, thresh. Out: best_score, confident.
module cls_margin
    import cls_sched_pkg::*;
#(
    parameter int NUM_CLASSES = 4,
    parameter int ACC_BITS    = 24
) (
    input  logic [NUM_CLASSES*ACC_BITS-1:0] scores_flat,
    input  logic [1:0]                      best_class,
    input  logic [ACC_BITS-1:0]             thresh,
    output logic [ACC_BITS-1:0]             best_score,
    output logic                            confident
);

    logic signed [ACC_BITS-1:0] s;
    logic signed [ACC_BITS-1:0] best;
    logic signed [ACC_BITS-1:0] second;
    logic signed [ACC_BITS:0]   margin;

    always_comb begin
        s      = '0;
        best   = '0;
        // Start at the most negative value so any real score wins.
        second = {1'b1, {(ACC_BITS-1){1'b0}}};
        for (int i = 0; i < NUM_CLASSES; i++) begin
            s = scores_flat[i*ACC_BITS +: ACC_BITS];
            if (2'(i) == best_class) begin
                best = s;
            end else if (s > second) begin
                second = s;
            end
        end
        margin = {best[ACC_BITS-1], best}
               - {second[ACC_BITS-1], second};
        best_score = best;
        confident  = margin >= $signed({1'b0, thresh});
    end

endmodule

// File: rtl/cls_scheduler.sv
// cls_scheduler: starts the array, streams a frame, publishes the argmax.
// Ports: clk/rst_n, enable/frame_ready/frame_done, bus (buffer+array),
// margin_thresh, cls_* result, busy, drop_count, timeout_err.
module cls_scheduler
    import cls_sched_pkg::*;
#(
    parameter int NUM_CLASSES     = 4,
    parameter int NUM_CELLS       = 1024,
    parameter int VALUE_BITS      = 6,
    parameter int ACC_BITS        = 24,
    parameter int PARALLEL_INPUTS = 4,
    parameter int TIMEOUT_CYCLES  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                frame_ready,
    output logic                frame_done,
    cls_scheduler_if.master     bus,
    input  logic [ACC_BITS-1:0] margin_thresh,
    output logic                cls_valid,
    output logic [1:0]          cls_class,
    output logic [ACC_BITS-1:0] cls_score,
    output logic                cls_confident,
    output logic                busy,
    output logic [7:0]          drop_count,
    output logic                timeout_err
);

    localparam int WORDS      = words_for(NUM_CELLS, PARALLEL_INPUTS);
    localparam int WADDR_BITS = addr_bits(WORDS);
    localparam int TW         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WADDR_BITS-1:0] LAST  = WADDR_BITS'(WORDS - 1);
    localparam logic [TW-1:0]         TLAST = TW'(TIMEOUT_CYCLES - 1);

    state_t                state_q, state_d;
    logic [WADDR_BITS-1:0] beat_q, beat_d;
    logic [TW-1:0]         wait_q;
    logic                  timeout_hit;

    logic                  start_d, rd_en_d, valid_d;
    logic                  done_d, pub_d, busy_d;
    logic [WADDR_BITS-1:0] rd_addr_d;
    logic                  drop_hit, capture;

    logic                  start_q, rd_en_q, valid_q;
    logic [WADDR_BITS-1:0] rd_addr_q;

    logic [ACC_BITS-1:0]   m_best;
    logic                  m_conf;

    cls_margin #(
        .NUM_CLASSES (NUM_CLASSES),
        .ACC_BITS    (ACC_BITS)
    ) u_margin (
        .scores_flat (bus.sa_scores_flat),
        .best_class  (bus.sa_best_class),
        .thresh      (margin_thresh),
        .best_score  (m_best),
        .confident   (m_conf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            if (state_q == S_WAIT && state_d == S_WAIT) begin
                wait_q <= wait_q + TW'(1);
            end else begin
                wait_q <= '0;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        timeout_hit = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (frame_ready && enable) state_d = S_START;
            end
            S_START: state_d = S_STREAM;
            S_STREAM: begin
                if (beat_q == LAST) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.sa_result_valid) begin
                    state_d = S_PUBLISH;
                end else if (wait_q == TLAST) begin
                    state_d     = S_IDLE;
                    timeout_hit = 1'b1;
                end
            end
            S_PUBLISH: begin
                // The cycle busy falls still accepts a new frame.
                if (frame_ready && enable) state_d = S_START;
                else                       state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are computed from the next state so that the registered
    // versions line up with the state they describe.
    always_comb begin
        beat_d    = '0;
        rd_addr_d = '0;
        if (state_q == S_STREAM) beat_d = beat_q + WADDR_BITS'(1);
        start_d = state_d == S_START;
        valid_d = state_d == S_STREAM;
        rd_en_d = start_d || (valid_d && beat_d != LAST);
        if (valid_d && beat_d != LAST) begin
            rd_addr_d = beat_d + WADDR_BITS'(1);
        end
        done_d   = state_d == S_WAIT && state_q != S_WAIT;
        pub_d    = state_d == S_PUBLISH;
        busy_d   = state_d != S_IDLE;
        drop_hit = frame_ready && (!enable ||
                   state_q inside {S_START, S_STREAM, S_WAIT});
        capture  = state_q == S_WAIT && bus.sa_result_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q       <= 1'b0;
            rd_en_q       <= 1'b0;
            rd_addr_q     <= '0;
            valid_q       <= 1'b0;
            frame_done    <= 1'b0;
            cls_valid     <= 1'b0;
            cls_class     <= '0;
            cls_score     <= '0;
            cls_confident <= 1'b0;
            busy          <= 1'b0;
            drop_count    <= '0;
            timeout_err   <= 1'b0;
        end else begin
            start_q    <= start_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            valid_q    <= valid_d;
            frame_done <= done_d;
            cls_valid  <= pub_d;
            busy       <= busy_d;
            if (capture) begin
                cls_class     <= bus.sa_best_class;
                cls_score     <= m_best;
                cls_confident <= m_conf;
            end
            if (drop_hit && drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
            if (timeout_hit) timeout_err <= 1'b1;
        end
    end

    assign bus.sa_start         = start_q;
    assign bus.fm_rd_en         = rd_en_q;
    assign bus.fm_rd_addr       = rd_addr_q;
    assign bus.sa_feature_valid = valid_q;
    // RAM data is already registered; gate it so idle beats read as 0.
    assign bus.sa_feature_in    = valid_q ? bus.fm_rd_data : '0;

endmodule
